// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared state type, default sizes and byte-parity helper for the SDP RAM
package ram_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DEPTH  = 256;

   // Widest word the parity helper handles; callers cast in and out of it.
   localparam int MAX_DATA_W = 512;
   localparam int MAX_STRB_W = MAX_DATA_W / 8;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // Even parity per byte: bit i makes byte i plus its parity bit hold an even count of ones.
   function automatic logic [MAX_STRB_W-1:0] byte_parity(input logic [MAX_DATA_W-1:0] data);
      logic [MAX_STRB_W-1:0] par;
      par = '0;
      for (int i = 0; i < MAX_STRB_W; i++) begin
         par[i] = ^data[8*i +: 8];
      end
      return par;
   endfunction

endpackage

// File: rtl/ram_sdp_array.sv
// rtl/ram_sdp_array.sv - bare simple-dual-port storage with per-lane write enables and unregistered read
module ram_sdp_array #(
   parameter int LANES  = 2,
   parameter int LANE_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic                    clk,
   input  logic [LANES-1:0]        we,
   input  logic [ADDR_W-1:0]       waddr,
   input  logic [LANES*LANE_W-1:0] wdata,
   input  logic [ADDR_W-1:0]       raddr,
   output logic [LANES*LANE_W-1:0] rdata
);

   logic [LANES*LANE_W-1:0] mem [DEPTH];

   // Lane-granular write; the controller only enables lanes for in-range addresses.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (we[i]) begin
            mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
         end
      end
   end

   // Out-of-range read addresses are masked by the controller, so this value is don't-care there.
   assign rdata = mem[raddr];

endmodule

// File: rtl/ram_sdp_ctrl.sv
// rtl/ram_sdp_ctrl.sv - SDP RAM controller: clear FSM, byte strobes, write-first bypass, range checks; optional parity via RAM_SDP_PARITY_EN
module ram_sdp_ctrl
   import ram_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  ready,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [DATA_W/8-1:0]   wr_strb,
`ifdef RAM_SDP_PARITY_EN
   input  logic                  par_inject,
`endif
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_valid,
   output logic                  rd_err
);

   localparam int STRB_W = DATA_W / 8;
`ifdef RAM_SDP_PARITY_EN
   localparam int LANE_W = 9;
`else
   localparam int LANE_W = 8;
`endif
   localparam int WORD_W = STRB_W * LANE_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   clr_ptr, clr_ptr_nxt;
   logic                wr_in_range, rd_in_range, collide, rd_fire;
   logic [STRB_W-1:0]   arr_we;
   logic [ADDR_W-1:0]   arr_waddr;
   logic [WORD_W-1:0]   arr_wdata, arr_rdata, wr_word;
   logic [DATA_W-1:0]   rd_merged;
   logic                rd_bad;

   // Compare with one extra bit so DEPTH == 2**ADDR_W is representable.
   assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
   assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;
   assign collide     = wr_en && wr_in_range && rd_in_range && (wr_addr == rd_addr);

`ifdef RAM_SDP_PARITY_EN
   logic [STRB_W-1:0] wr_par;
   assign wr_par = STRB_W'(byte_parity(MAX_DATA_W'(wr_data)));
`endif

   // Pack each write byte into its storage lane, with its check bit when parity is built in.
   always_comb begin
      wr_word = '0;
      for (int i = 0; i < STRB_W; i++) begin
`ifdef RAM_SDP_PARITY_EN
         wr_word[i*LANE_W +: LANE_W] = {wr_par[i] ^ par_inject, wr_data[8*i +: 8]};
`else
         wr_word[i*LANE_W +: LANE_W] = wr_data[8*i +: 8];
`endif
      end
   end

   // State and clear pointer; reset always restarts the clear from address 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_CLEAR;
         clr_ptr <= '0;
      end else begin
         state   <= state_nxt;
         clr_ptr <= clr_ptr_nxt;
      end
   end

   // Next state and write-port steering: the clear owns the array until the last word is zeroed.
   always_comb begin
      state_nxt   = state;
      clr_ptr_nxt = clr_ptr;
      ready       = 1'b0;
      arr_we      = '0;
      arr_waddr   = wr_addr;
      arr_wdata   = wr_word;
      rd_fire     = 1'b0;
      case (state)
         ST_CLEAR: begin
            arr_we    = '1;
            arr_waddr = clr_ptr;
            arr_wdata = '0;
            if (clr_ptr == LAST_ADDR) begin
               state_nxt   = ST_RUN;
               clr_ptr_nxt = '0;
            end else begin
               clr_ptr_nxt = clr_ptr + ADDR_W'(1);
            end
         end
         ST_RUN: begin
            ready = 1'b1;
            if (wr_en && wr_in_range) begin
               arr_we = wr_strb;
            end
            rd_fire = rd_en;
         end
         default: begin
            state_nxt = ST_CLEAR;
         end
      endcase
   end

   ram_sdp_array #(
      .LANES  (STRB_W),
      .LANE_W (LANE_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .waddr (arr_waddr),
      .wdata (arr_wdata),
      .raddr (rd_addr),
      .rdata (arr_rdata)
   );

   // Write-first merge per byte; stored-parity mismatches count only on bytes taken from memory.
   always_comb begin
      rd_merged = '0;
      rd_bad    = 1'b0;
      for (int i = 0; i < STRB_W; i++) begin
         if (collide && wr_strb[i]) begin
            rd_merged[8*i +: 8] = wr_data[8*i +: 8];
         end else begin
            rd_merged[8*i +: 8] = arr_rdata[i*LANE_W +: 8];
`ifdef RAM_SDP_PARITY_EN
            rd_bad = rd_bad | (^arr_rdata[i*LANE_W +: LANE_W]);
`endif
         end
      end
   end

   // Read output registers: one-cycle latency, data held when idle, err only alongside valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         rd_data  <= '0;
      end else if (rd_fire) begin
         rd_valid <= 1'b1;
         if (rd_in_range) begin
            rd_data <= rd_merged;
            rd_err  <= rd_bad;
         end else begin
            rd_data <= '0;
            rd_err  <= 1'b1;
         end
      end else begin
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ram_sdp_ctrl.sv
// tb/tb_ram_sdp_ctrl.sv - self-checking bench for ram_sdp_ctrl (DEPTH 256 and 200 instances)
module tb_ram_sdp_ctrl;

   localparam int D0 = 256;
   localparam int D1 = 200;
   localparam int NV = 18;

   logic        clk = 1'b0;
   logic        rst, wr_en, rd_en, par_inject;
   logic [7:0]  wr_addr, rd_addr;
   logic [15:0] wr_data;
   logic [1:0]  wr_strb;
   logic        ready_o    [2];
   logic        rd_valid_o [2];
   logic        rd_err_o   [2];
   logic [15:0] rd_data_o  [2];

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   ram_sdp_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(D0)) u_dut0 (
      .clk      (clk),
      .rst      (rst),
      .ready    (ready_o[0]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_strb  (wr_strb),
`ifdef RAM_SDP_PARITY_EN
      .par_inject (par_inject),
`endif
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data_o[0]),
      .rd_valid (rd_valid_o[0]),
      .rd_err   (rd_err_o[0])
   );

   ram_sdp_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(D1)) u_dut1 (
      .clk      (clk),
      .rst      (rst),
      .ready    (ready_o[1]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_strb  (wr_strb),
`ifdef RAM_SDP_PARITY_EN
      .par_inject (par_inject),
`endif
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data_o[1]),
      .rd_valid (rd_valid_o[1]),
      .rd_err   (rd_err_o[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int dep(input int k);
      return (k == 0) ? D0 : D1;
   endfunction

   // Reference model: memory as plain arrays, cleared in one step at reset; ready after DEPTH low cycles.
   logic [15:0] m_mem  [2][256];
   logic [1:0]  m_par  [2][256];
   bit          m_ready [2];
   int          m_cnt   [2];
   logic        m_valid [2];
   logic        m_err   [2];
   logic [15:0] m_data  [2];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_ready[k] = 1'b0;
            m_cnt[k]   = 0;
            m_valid[k] = 1'b0;
            m_err[k]   = 1'b0;
            m_data[k]  = 16'h0;
            for (int a = 0; a < 256; a++) begin
               m_mem[k][a] = 16'h0;
               m_par[k][a] = 2'b00;
            end
         end else if (!m_ready[k]) begin
            m_valid[k] = 1'b0;
            m_err[k]   = 1'b0;
            m_cnt[k]++;
            if (m_cnt[k] == dep(k)) m_ready[k] = 1'b1;
         end else begin
            m_valid[k] = rd_en;
            m_err[k]   = 1'b0;
            if (rd_en) begin
               if (int'(rd_addr) >= dep(k)) begin
                  m_data[k] = 16'h0;
                  m_err[k]  = 1'b1;
               end else begin
                  for (int b = 0; b < 2; b++) begin
                     if (wr_en && wr_addr == rd_addr && wr_strb[b]) begin
                        m_data[k][8*b +: 8] = wr_data[8*b +: 8];
                     end else begin
                        m_data[k][8*b +: 8] = m_mem[k][rd_addr][8*b +: 8];
                        if (m_par[k][rd_addr][b] != ^m_mem[k][rd_addr][8*b +: 8]) m_err[k] = 1'b1;
                     end
                  end
               end
            end
            if (wr_en && int'(wr_addr) < dep(k)) begin
               for (int b = 0; b < 2; b++) begin
                  if (wr_strb[b]) begin
                     m_mem[k][wr_addr][8*b +: 8] = wr_data[8*b +: 8];
                     m_par[k][wr_addr][b] = (^wr_data[8*b +: 8]) ^ par_inject;
                  end
               end
            end
         end
      end
   end

   // Compare both instances against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_ready%0d", k), 32'(ready_o[k]), 32'(m_ready[k]));
            chk($sformatf("model_valid%0d", k), 32'(rd_valid_o[k]), 32'(m_valid[k]));
            chk($sformatf("model_err%0d", k), 32'(rd_err_o[k]), 32'(m_err[k]));
            chk($sformatf("model_data%0d", k), 32'(rd_data_o[k]), 32'(m_data[k]));
         end
      end
   end

   typedef struct {
      logic        we;
      logic [7:0]  wa;
      logic [15:0] wd;
      logic [1:0]  ws;
      logic        re;
      logic [7:0]  ra;
      logic        ev;
      logic [15:0] d0;
      logic        e0;
      logic [15:0] d1;
      logic        e1;
   } vec_t;

   vec_t tbl [NV];

   function automatic logic [7:0] pick();
      case ($urandom_range(0, 2))
         0:       return 8'($urandom_range(0, 7));
         1:       return 8'($urandom_range(196, 255));
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic idle();
      wr_en = 1'b0; rd_en = 1'b0; par_inject = 1'b0;
   endtask

   initial begin
      int  n, t0, t1;
      bit  seen_v;

      rst = 1'b1; wr_addr = '0; rd_addr = '0; wr_data = '0; wr_strb = '0;
      idle();

      //            we    wa      wd        ws     re    ra      ev    d0        e0    d1        e1
      tbl[0]  = '{1'b0, 8'd0,   16'h0000, 2'b00, 1'b1, 8'd0,   1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[1]  = '{1'b0, 8'd0,   16'h0000, 2'b00, 1'b1, 8'd128, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[2]  = '{1'b0, 8'd0,   16'h0000, 2'b00, 1'b1, 8'd255, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b1};
      tbl[3]  = '{1'b0, 8'd0,   16'h0000, 2'b00, 1'b1, 8'd5,   1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[4]  = '{1'b0, 8'd0,   16'h0000, 2'b00, 1'b1, 8'd199, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[5]  = '{1'b0, 8'd0,   16'h0000, 2'b00, 1'b1, 8'd200, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b1};
      tbl[6]  = '{1'b1, 8'd3,   16'h1234, 2'b11, 1'b0, 8'd0,   1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[7]  = '{1'b1, 8'd3,   16'hABCD, 2'b01, 1'b0, 8'd0,   1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[8]  = '{1'b0, 8'd0,   16'h0000, 2'b00, 1'b1, 8'd3,   1'b1, 16'h12CD, 1'b0, 16'h12CD, 1'b0};
      tbl[9]  = '{1'b1, 8'd3,   16'hFFFF, 2'b00, 1'b1, 8'd3,   1'b1, 16'h12CD, 1'b0, 16'h12CD, 1'b0};
      tbl[10] = '{1'b1, 8'd7,   16'h1111, 2'b11, 1'b0, 8'd0,   1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[11] = '{1'b1, 8'd7,   16'h2222, 2'b10, 1'b1, 8'd7,   1'b1, 16'h2211, 1'b0, 16'h2211, 1'b0};
      tbl[12] = '{1'b0, 8'd0,   16'h0000, 2'b00, 1'b1, 8'd7,   1'b1, 16'h2211, 1'b0, 16'h2211, 1'b0};
      tbl[13] = '{1'b1, 8'd210, 16'h5555, 2'b11, 1'b0, 8'd0,   1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[14] = '{1'b0, 8'd0,   16'h0000, 2'b00, 1'b1, 8'd210, 1'b1, 16'h5555, 1'b0, 16'h0000, 1'b1};
      tbl[15] = '{1'b0, 8'd0,   16'h0000, 2'b00, 1'b1, 8'd10,  1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[16] = '{1'b1, 8'd255, 16'hA55A, 2'b11, 1'b1, 8'd255, 1'b1, 16'hA55A, 1'b0, 16'h0000, 1'b1};
      tbl[17] = '{1'b0, 8'd0,   16'h0000, 2'b00, 1'b0, 8'd0,   1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};

      // Reset held for two cycles, then check the reset state.
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      chk("reset_ready0", 32'(ready_o[0]), 32'd0);
      chk("reset_ready1", 32'(ready_o[1]), 32'd0);
      chk("reset_valid0", 32'(rd_valid_o[0]), 32'd0);
      chk("reset_err0", 32'(rd_err_o[0]), 32'd0);
      chk("reset_data0", 32'(rd_data_o[0]), 32'd0);

      // Clear sequence with traffic that must be ignored.
      rst = 1'b0;
      wr_en = 1'b1; wr_addr = 8'd5; wr_data = 16'hBEEF; wr_strb = 2'b11;
      rd_en = 1'b1; rd_addr = 8'd5;
      n = 0; t0 = 0; t1 = 0; seen_v = 1'b0;
      while (n < 400 && t0 == 0) begin
         @(posedge clk); #1;
         n++;
         if (rd_valid_o[0] !== 1'b0 || rd_valid_o[1] !== 1'b0) seen_v = 1'b1;
         if (ready_o[1] === 1'b1 && t1 == 0) begin
            t1 = n;
            idle();
         end
         if (ready_o[0] === 1'b1 && t0 == 0) t0 = n;
      end
      chk("clear_len_256", 32'(t0), 32'd256);
      chk("clear_len_200", 32'(t1), 32'd200);
      chk("no_valid_in_clear", 32'(seen_v), 32'd0);

      // Directed vectors: each row is one cycle; results appear the following cycle.
      for (int i = 0; i < NV; i++) begin
         wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; wr_strb = tbl[i].ws;
         rd_en = tbl[i].re; rd_addr = tbl[i].ra;
         @(posedge clk); #1;
         chk($sformatf("vec%0d_valid0", i), 32'(rd_valid_o[0]), 32'(tbl[i].ev));
         chk($sformatf("vec%0d_valid1", i), 32'(rd_valid_o[1]), 32'(tbl[i].ev));
         chk($sformatf("vec%0d_err0", i), 32'(rd_err_o[0]), 32'(tbl[i].e0));
         chk($sformatf("vec%0d_err1", i), 32'(rd_err_o[1]), 32'(tbl[i].e1));
         if (tbl[i].ev) begin
            chk($sformatf("vec%0d_data0", i), 32'(rd_data_o[0]), 32'(tbl[i].d0));
            chk($sformatf("vec%0d_data1", i), 32'(rd_data_o[1]), 32'(tbl[i].d1));
         end
      end
      idle();

      // Reset in the middle of a read, then re-clear.
      wr_en = 1'b1; wr_addr = 8'd0; wr_data = 16'hFFFF; wr_strb = 2'b11;
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b1; rd_addr = 8'd0;
      @(posedge clk); #1;
      chk("pre_reset_data", 32'(rd_data_o[0]), 32'hFFFF);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_reset_valid", 32'(rd_valid_o[0]), 32'd0);
      chk("mid_reset_ready", 32'(ready_o[0]), 32'd0);
      rst = 1'b0; idle();
      n = 0;
      while (n < 400 && ready_o[0] !== 1'b1) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reclear_timeout", 32'(n < 400), 32'd1);
      rd_en = 1'b1; rd_addr = 8'd0;
      @(posedge clk); #1;
      chk("reclear_valid", 32'(rd_valid_o[0]), 32'd1);
      chk("reclear_data", 32'(rd_data_o[0]), 32'h0000);
      idle();

`ifdef RAM_SDP_PARITY_EN
      // Injected parity fault is reported on read while data comes back intact.
      wr_en = 1'b1; wr_addr = 8'd9; wr_data = 16'h00A5; wr_strb = 2'b01; par_inject = 1'b1;
      @(posedge clk); #1;
      idle(); rd_en = 1'b1; rd_addr = 8'd9;
      @(posedge clk); #1;
      chk("par_inject_err", 32'(rd_err_o[0]), 32'd1);
      chk("par_inject_data", 32'(rd_data_o[0]), 32'h00A5);
      idle();
`endif

      // Randomised traffic, including rare resets, checked by the model.
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         rst     = ($urandom_range(0, 999) == 0);
         wr_en   = 1'($urandom_range(0, 1));
         rd_en   = 1'($urandom_range(0, 1));
         wr_addr = pick();
         rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : pick();
         wr_data = 16'($urandom);
         wr_strb = 2'($urandom);
`ifdef RAM_SDP_PARITY_EN
         par_inject = ($urandom_range(0, 7) == 0);
`endif
      end
      @(posedge clk); #1;
      rst = 1'b0; idle();
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
